// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: synchronizes rx, frames DATA_BITS LSB-first with
// configurable stop length, and reports valid/done/framing/overrun status.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
    localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [4:0]           s;
    logic [NW-1:0]        n;
    logic [DATA_BITS-1:0] b;

    logic       sync1;
    logic       rx_s;
    logic       rx_prev;
    logic [1:0] settle;
    logic       armed;

    // The synchronizer resets high, so a line already low at reset release would look
    // like a falling edge; armed waits until a genuine high has been synchronized.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            settle  <= '0;
            armed   <= 1'b0;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
            settle  <= {settle[0], 1'b1};
            if (settle[1] && rx_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_done     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (rx_ack)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (armed && rx_prev && !rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == 5'd7) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 5'd15) begin
                            s <= '0;
                            b <= DATA_BITS'({rx_s, b} >> 1);
                            if (n == N_LAST)
                                state <= STOP;
                            else
                                n <= n + NW'(1);
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP) begin
                            // A completion wins over a same-edge ack: the new word stays valid.
                            state     <= IDLE;
                            rx_data   <= b;
                            rx_done   <= 1'b1;
                            frame_err <= ~rx_s;
                            rx_valid  <= 1'b1;
                            if (rx_valid && !rx_ack)
                                overrun_err <= 1'b1;
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clks (64 clks per bit), 8 data bits,
// frames driven on the falling clock edge, outputs sampled on the falling edge.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_done;
    logic       frame_err;
    logic       overrun_err;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int tcnt     = 0;
    int d0;

    uart_rx #(.DATA_BITS(8), .SB_TICK(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_done     (rx_done),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = tcnt + 1;
            tick = (tcnt % 4 == 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rx_done === 1'b1)
            done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start bit begins on a negedge where tcnt%4==1, so ticks land on the 4th, 8th, ...
    // posedge after it; the stop bit is then sampled on the 608th posedge.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int ack_at, input int rst_at, input bit check_lat);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        do @(posedge clk); while (tcnt % 4 != 0);
        @(negedge clk);
        for (int i = 0; i < 640; i++) begin
            rx     = bits[i / 64];
            rx_ack = (i == ack_at);
            rst    = (i == rst_at);
            if (check_lat && i == 607) check("done_early", 32'(rx_done), 32'd0);
            if (check_lat && i == 608) check("done_latency", 32'(rx_done), 32'd1);
            @(negedge clk);
        end
        rx     = 1'b1;
        rx_ack = 1'b0;
        rst    = 1'b0;
        repeat (32) @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rx     = 1'b1;
        rx_ack = 1'b0;
        rst    = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_done", 32'(rx_done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_oerr", 32'(overrun_err), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Good frame 0x55
        d0 = done_cnt;
        send_frame(8'h55, 1'b1, -1, -1, 1'b1);
        check("f55_data", 32'(rx_data), 32'h55);
        check("f55_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("f55_ferr", 32'(frame_err), 32'd0);
        check("f55_valid", 32'(rx_valid), 32'd1);
        check("f55_oerr", 32'(overrun_err), 32'd0);

        // False start: 16 clks low
        d0 = done_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (700) @(negedge clk);
        check("false_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("false_valid", 32'(rx_valid), 32'd1);
        check("false_data", 32'(rx_data), 32'h55);

        ack_pulse();
        check("ack_valid", 32'(rx_valid), 32'd0);
        ack_pulse();
        check("ack_idle_valid", 32'(rx_valid), 32'd0);
        check("ack_idle_oerr", 32'(overrun_err), 32'd0);

        // Framing error then recovery
        d0 = done_cnt;
        send_frame(8'hA3, 1'b0, -1, -1, 1'b1);
        check("fA3_data", 32'(rx_data), 32'hA3);
        check("fA3_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("fA3_ferr", 32'(frame_err), 32'd1);
        check("fA3_valid", 32'(rx_valid), 32'd1);
        ack_pulse();
        send_frame(8'h0F, 1'b1, -1, -1, 1'b1);
        check("f0F_data", 32'(rx_data), 32'h0F);
        check("f0F_ferr", 32'(frame_err), 32'd0);
        ack_pulse();

        // Overrun
        send_frame(8'h12, 1'b1, -1, -1, 1'b0);
        check("f12_oerr", 32'(overrun_err), 32'd0);
        send_frame(8'h34, 1'b1, -1, -1, 1'b0);
        check("f34_data", 32'(rx_data), 32'h34);
        check("f34_oerr", 32'(overrun_err), 32'd1);
        check("f34_valid", 32'(rx_valid), 32'd1);
        ack_pulse();
        check("ovr_ack_valid", 32'(rx_valid), 32'd0);
        check("ovr_sticky", 32'(overrun_err), 32'd1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_clr_oerr", 32'(overrun_err), 32'd0);
        repeat (10) @(negedge clk);

        // Ack on the completion edge
        d0 = done_cnt;
        send_frame(8'h11, 1'b1, -1, -1, 1'b0);
        send_frame(8'h22, 1'b1, 607, -1, 1'b1);
        check("f22_valid", 32'(rx_valid), 32'd1);
        check("f22_data", 32'(rx_data), 32'h22);
        check("f22_oerr", 32'(overrun_err), 32'd0);
        check("f22_done_cnt", 32'(done_cnt - d0), 32'd2);

        // Reset during data bit 3 of 0xFF
        d0 = done_cnt;
        send_frame(8'hFF, 1'b1, -1, 280, 1'b0);
        check("midrst_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("midrst_data", 32'(rx_data), 32'h0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        check("midrst_oerr", 32'(overrun_err), 32'd0);
        check("midrst_done", 32'(rx_done), 32'd0);
        d0 = done_cnt;
        send_frame(8'h81, 1'b1, -1, -1, 1'b1);
        check("f81_data", 32'(rx_data), 32'h81);
        check("f81_valid", 32'(rx_valid), 32'd1);
        check("f81_ferr", 32'(frame_err), 32'd0);
        check("f81_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Line held low across reset release must not start a frame
        d0 = done_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        rx = 1'b1;
        repeat (700) @(negedge clk);
        check("lowrst_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("lowrst_valid", 32'(rx_valid), 32'd0);
        d0 = done_cnt;
        send_frame(8'h3C, 1'b1, -1, -1, 1'b1);
        check("f3C_data", 32'(rx_data), 32'h3C);
        check("f3C_done_cnt", 32'(done_cnt - d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
